// File: rtl/if_fetch_if.sv
// Instruction-memory read bus: one address handshake followed by one data handshake.
interface if_fetch_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        im_rready;

  modport master (
    output im_req,
    output im_addr,
    output im_rready,
    input  im_ready,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    input  im_rready,
    output im_ready,
    output im_rvalid,
    output im_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one instruction read at a time and hands
// the result to IF/ID. Optional fetch-timeout flag enabled by IF_FETCH_TIMEOUT_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_en,
  input  logic [31:0] trap_vector,
  input  logic        WFI,
  input  logic        interrupt_pulse,
  if_fetch_if.master  im_bus,
  output logic [31:0] PC_out,
  output logic [31:0] PCadd4_Out,
  output logic [31:0] IM_Instruction,
  output logic        stall,
  output logic        fetch_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] hold_q, hold_d;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        wfi_hold;
  logic        handover;
  logic [31:0] next_pc;

  assign redirect    = trap_en | branch_taken;
  assign redirect_pc = trap_en ? trap_vector : branch_target;
  // A wake event in the same cycle as WFI cancels the hold.
  assign wfi_hold    = WFI & ~interrupt_pulse;
  assign handover    = (state_q == StData) & im_bus.im_rvalid & ~drop_q;

  // PC to fetch after a handover, trap first, then branch, then sequential.
  always_comb begin
    next_pc = pc_q;
    if (trap_en) begin
      next_pc = trap_vector;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (pc_write) begin
      next_pc = pc_q + 32'd4;
    end
  end

  // Next-state logic for the fetch FSM, PC and stale-response tracking.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    drop_d    = drop_q;
    hold_d    = hold_q;
    unique case (state_q)
      StIdle: begin
        // Nothing outstanding, so a redirect can go straight into the PC.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (!wfi_hold) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (im_bus.im_ready) begin
          state_d = StData;
        end
        if (redirect) begin
          pend_pc_d = redirect_pc;
          drop_d    = 1'b1;
        end
      end
      StData: begin
        if (im_bus.im_rvalid) begin
          if (!drop_q) begin
            hold_d  = im_bus.im_rdata;
            pc_d    = next_pc;
            state_d = wfi_hold ? StIdle : StAddr;
          end else begin
            // Stale response: discard it and fetch the pending redirect target.
            drop_d  = 1'b0;
            pc_d    = pend_pc_q;
            state_d = StAddr;
            if (redirect) begin
              pend_pc_d = redirect_pc;
              drop_d    = 1'b1;
            end
          end
        end else if (redirect) begin
          pend_pc_d = redirect_pc;
          drop_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0;
      drop_q    <= 1'b0;
      hold_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      drop_q    <= drop_d;
      hold_q    <= hold_d;
    end
  end

  assign im_bus.im_req    = (state_q == StAddr);
  assign im_bus.im_addr   = pc_q;
  assign im_bus.im_rready = (state_q == StData);

  assign PC_out         = pc_q;
  assign PCadd4_Out     = pc_q + 32'd4;
  assign IM_Instruction = handover ? im_bus.im_rdata : hold_q;
  assign stall          = ~handover;

`ifdef IF_FETCH_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       err_q, err_d;

  // Count cycles spent on the current request; restart on every new address phase.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_d == StAddr) && (state_q != StAddr)) begin
      tmo_cnt_d = 8'd0;
    end else if ((state_q != StIdle) && (tmo_cnt_q != 8'hFF)) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
    err_d = err_q | (tmo_cnt_q == 8'(TIMEOUT_CYCLES));
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign fetch_err          = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by randomized traffic, all
// checked every cycle against a fetch-level reference model and a memory scoreboard.
module tb_if_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        trap_en = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic        WFI = 1'b0;
  logic        interrupt_pulse = 1'b0;
  logic [31:0] PC_out, PCadd4_Out, IM_Instruction;
  logic        stall, fetch_err;

  if_fetch_if bus();

  if_fetch #(
    .RESET_PC       (RST_PC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_write        (pc_write),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .trap_en         (trap_en),
    .trap_vector     (trap_vector),
    .WFI             (WFI),
    .interrupt_pulse (interrupt_pulse),
    .im_bus          (bus),
    .PC_out          (PC_out),
    .PCadd4_Out      (PCadd4_Out),
    .IM_Instruction  (IM_Instruction),
    .stall           (stall),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory side: one outstanding read, data = address ^ key.
  logic        rdy_en = 1'b0;
  logic        rv_en = 1'b0;
  logic [31:0] key = 32'h0;
  logic        mem_busy = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic        obs_req, obs_rready;
  logic [31:0] obs_addr;
  logic [31:0] ho_q[$];

  // Reference model: 0 = no request, 1 = address offered, 2 = awaiting data.
  int          m_phase;
  logic [31:0] m_pc, m_pend, m_hold;
  logic        m_drop, m_err;
  int          m_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = RST_PC;
    m_pend  = 32'h0;
    m_hold  = 32'h0;
    m_drop  = 1'b0;
    m_err   = 1'b0;
    m_wait  = 0;
  endtask

  task automatic step();
    logic        ho;
    logic        redir;
    logic        hold;
    logic [31:0] tgt;
    int          old_phase;
    @(negedge clk);
    bus.im_ready  = rdy_en;
    bus.im_rvalid = mem_busy && rv_en;
    bus.im_rdata  = mem_busy ? (acc_addr ^ key) : $urandom;
    #1;
    obs_req    = bus.im_req;
    obs_addr   = bus.im_addr;
    obs_rready = bus.im_rready;
    ho = rst && (m_phase == 2) && bus.im_rvalid && !m_drop;
    check("stall", stall, !ho);
    check("im_req", bus.im_req, m_phase == 1);
    check("im_rready", bus.im_rready, m_phase == 2);
    if (m_phase == 1) check("im_addr", bus.im_addr, m_pc);
    check("PC_out", PC_out, m_pc);
    check("PCadd4_Out", PCadd4_Out, m_pc + 32'd4);
    check("IM_Instruction", IM_Instruction, ho ? (acc_addr ^ key) : m_hold);
    check("fetch_err", fetch_err, m_err);
    if (ho) begin
      check("handover_pc", PC_out, acc_addr);
      ho_q.push_back(acc_addr);
    end
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      if (obs_req && rdy_en) begin
        mem_busy = 1'b1;
        acc_addr = obs_addr;
      end else if (obs_rready && bus.im_rvalid) begin
        mem_busy = 1'b0;
      end
      redir     = trap_en || branch_taken;
      tgt       = trap_en ? trap_vector : branch_target;
      hold      = WFI && !interrupt_pulse;
      old_phase = m_phase;
`ifdef IF_FETCH_TIMEOUT_EN
      if (m_wait == TMO) m_err = 1'b1;
`endif
      if (m_phase != 0 && m_wait < 255) m_wait++;
      case (m_phase)
        0: begin
          if (redir) m_pc = tgt;
          if (!hold) m_phase = 1;
        end
        1: begin
          if (rdy_en) m_phase = 2;
          if (redir) begin
            m_pend = tgt;
            m_drop = 1'b1;
          end
        end
        default: begin
          if (bus.im_rvalid && !m_drop) begin
            m_hold = acc_addr ^ key;
            if (trap_en) m_pc = trap_vector;
            else if (branch_taken) m_pc = branch_target;
            else if (pc_write) m_pc = m_pc + 32'd4;
            m_phase = hold ? 0 : 1;
          end else if (bus.im_rvalid) begin
            m_drop  = 1'b0;
            m_pc    = m_pend;
            m_phase = 1;
            if (redir) begin
              m_pend = tgt;
              m_drop = 1'b1;
            end
          end else if (redir) begin
            m_pend = tgt;
            m_drop = 1'b1;
          end
        end
      endcase
      if (m_phase == 1 && old_phase != 1) m_wait = 0;
    end
    #1;
  endtask

  task automatic run_until(input int ph, input int budget);
    int n = 0;
    while (m_phase != ph && n < budget) begin
      step();
      n++;
    end
    check("wait_bound", m_phase, ph);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.im_ready  = 1'b0;
    bus.im_rvalid = 1'b0;
    bus.im_rdata  = 32'h0;
    model_reset();

    // Reset values, then release with memory always ready and data = address.
    repeat (3) step();
    rst    = 1'b1;
    rdy_en = 1'b1;
    rv_en  = 1'b1;
    repeat (7) step();
    check("ho_count_0_4_8", ho_q.size(), 3);
    if (ho_q.size() == 3) begin
      check("ho0", ho_q[0], 32'h0);
      check("ho1", ho_q[1], 32'h4);
      check("ho2", ho_q[2], 32'h8);
    end

    // Branch during DATA with the response held off: old data dropped, refetch at 0x100.
    ho_q.delete();
    rv_en = 1'b0;
    run_until(2, 10);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step();
    branch_taken = 1'b0;
    repeat (2) step();
    rv_en = 1'b1;
    step();
    check("branch_drop_no_ho", ho_q.size(), 0);
    check("branch_addr", bus.im_addr, 32'h100);
    repeat (2) step();
    check("branch_ho_count", ho_q.size(), 1);
    if (ho_q.size() == 1) check("branch_ho_pc", ho_q[0], 32'h100);

    // Trap beats branch at handover.
    rv_en = 1'b0;
    run_until(2, 10);
    trap_en       = 1'b1;
    trap_vector   = 32'h200;
    branch_taken  = 1'b1;
    branch_target = 32'h80;
    rv_en         = 1'b1;
    step();
    trap_en      = 1'b0;
    branch_taken = 1'b0;
    check("trap_prio_addr", bus.im_addr, 32'h200);

    // WFI after a handover holds fetch; wake with a trap to 0x40.
    rv_en = 1'b0;
    run_until(2, 10);
    WFI   = 1'b1;
    rv_en = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("wfi_no_req", obs_req, 1'b0);
    end
    interrupt_pulse = 1'b1;
    trap_en         = 1'b1;
    trap_vector     = 32'h40;
    step();
    interrupt_pulse = 1'b0;
    trap_en         = 1'b0;
    WFI             = 1'b0;
    check("wake_addr", bus.im_addr, 32'h40);
    step();
    check("wake_req", obs_req, 1'b1);

    // Reset in the middle of a transaction; the late response must be ignored.
    rv_en = 1'b0;
    run_until(2, 10);
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_rready", bus.im_rready, 1'b0);
    check("rst_req", bus.im_req, 1'b0);
    check("rst_stall", stall, 1'b1);
    check("rst_pc", PC_out, RST_PC);
    rv_en = 1'b1;
    repeat (2) step();
    mem_busy = 1'b0;
    rst      = 1'b1;
    ho_q.delete();

    // pc_write low at handover of PC 8 refetches 8.
    begin
      int n = 0;
      while (ho_q.size() < 2 && n < 20) begin
        step();
        n++;
      end
    end
    rv_en = 1'b0;
    run_until(2, 10);
    check("pcw_pc_before", PC_out, 32'h8);
    pc_write = 1'b0;
    rv_en    = 1'b1;
    step();
    pc_write = 1'b1;
    check("pcw_pc_out", PC_out, 32'h8);
    check("pcw_addr", bus.im_addr, 32'h8);

    // Randomized traffic, including the 0xFFFF_FFFC wrap.
    key = $urandom;
    for (int i = 0; i < 3000; i++) begin
      trap_en         = ($urandom % 20) == 0;
      trap_vector     = (($urandom % 4) == 0) ? 32'hFFFF_FFFC : $urandom;
      branch_taken    = ($urandom % 10) == 0;
      branch_target   = $urandom;
      pc_write        = ($urandom % 5) != 0;
      WFI             = ($urandom % 8) == 0;
      interrupt_pulse = ($urandom % 3) == 0;
      rdy_en          = ($urandom % 5) < 3;
      rv_en           = ($urandom % 5) < 3;
      step();
    end
    trap_en         = 1'b0;
    branch_taken    = 1'b0;
    WFI             = 1'b0;
    interrupt_pulse = 1'b0;
    pc_write        = 1'b1;

`ifdef IF_FETCH_TIMEOUT_EN
    // Response withheld long enough to trip the sticky timeout flag.
    rst = 1'b0;
    model_reset();
    mem_busy = 1'b0;
    step();
    rst    = 1'b1;
    rdy_en = 1'b1;
    rv_en  = 1'b0;
    repeat (270) step();
    check("timeout_set", fetch_err, 1'b1);
    rv_en = 1'b1;
    repeat (4) step();
    check("timeout_sticky", fetch_err, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the program counter and issues one instruction read at a time to the instruction-memory bus (AXI-style address/data handshake). It hands `PC_out`, `PCadd4_Out` and `IM_Instruction` to IF/ID, and drives `stall` while no instruction is available. It also applies branch/trap redirects and holds fetch during WFI.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `TIMEOUT_CYCLES`, 255, fetch-timeout limit; used only with `IF_FETCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low: state is reset while `rst`=0.
- `pc_write`  in  1  hazard-unit enable; 0 = do not advance the PC at handover.
- `branch_taken`  in  1  branch/jump redirect request.
- `branch_target`  in  32  redirect address for `branch_taken`.
- `trap_en`  in  1  trap/interrupt/mret redirect request; takes priority over branch.
- `trap_vector`  in  32  redirect address for `trap_en`.
- `WFI`  in  1  wait-for-interrupt active.
- `interrupt_pulse`  in  1  wake event.
- `im_req`  out  1  read-address valid.
- `im_addr`  out  32  read address.
- `im_ready`  in  1  address accepted.
- `im_rvalid`  in  1  read data valid.
- `im_rdata`  in  32  read data.
- `im_rready`  out  1  read data accept.
- `PC_out`  out  32  PC of the instruction being handed over.
- `PCadd4_Out`  out  32  `PC_out`+4.
- `IM_Instruction`  out  32  fetched instruction.
- `stall`  out  1  1 = no valid instruction for IF/ID this cycle.
- `fetch_err`  out  1  sticky timeout flag; tied 0 without the macro.

## Operation
- FSM states: IDLE, ADDR, DATA. Exactly one request is outstanding at a time.
- IDLE: move to ADDR unless `WFI && !interrupt_pulse`, in which case stay in IDLE.
- ADDR: `im_req`=1 and `im_addr`=pc. `im_addr` stays stable until `im_ready`. On `im_ready`, go to DATA.
- DATA: `im_rready`=1. On `im_rvalid`:
  - If the drop flag is clear: **handover**.
  - If the drop flag is set: discard the data, clear drop, set pc = `pend_pc`, go to ADDR.
- Handover: `stall`=0 and `IM_Instruction`=`im_rdata` (combinational pass-through). The data is also captured into a hold register that drives `IM_Instruction` in all other cycles.
- Next pc at handover, in priority order: `trap_vector` if `trap_en`; else `branch_target` if `branch_taken`; else pc+4 if `pc_write`; else pc unchanged (same address is refetched). Next state: ADDR, or IDLE if `WFI && !interrupt_pulse`.
- Redirect outside a handover cycle:
  - In IDLE: pc is loaded with the target directly.
  - In ADDR or DATA: `pend_pc`=target and drop=1. The latest redirect wins; trap beats branch in the same cycle.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. Bits [1:0] are passed through unchecked.
- `PC_out` always equals the current pc register. `PCadd4_Out` = pc+4.
- `stall` = !(DATA && `im_rvalid` && !drop).

## Timing
- Reset values: state IDLE, pc=`RESET_PC`, drop=0, `im_req`=0, `im_addr`=`RESET_PC`, `im_rready`=0, `IM_Instruction`=0, `PC_out`=`RESET_PC`, `PCadd4_Out`=`RESET_PC`+4, `stall`=1, `fetch_err`=0.
- After reset release: the first edge gives ADDR. With `im_ready` and `im_rvalid` both high immediately, the first handover occurs 2 cycles after release. Steady-state throughput is 1 instruction per 2 cycles.
- A redirect takes effect on the request after the current one completes. Worst case, one stale response is dropped, costing 2 extra cycles.
- `WFI` with `interrupt_pulse` in the same cycle: wake wins and no IDLE hold occurs.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately. Any in-flight response arriving after reset is ignored, because `im_rready`=0.

## Configuration
- `IF_FETCH_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering ADDR and increments each cycle spent in ADDR or DATA.
  - When it reaches `TIMEOUT_CYCLES`, `fetch_err` is set and stays set until reset. Fetch behaviour is otherwise unchanged.
- `IF_FETCH_TIMEOUT_EN` undefined: there is no counter and `fetch_err` is constant 0.

## Test plan
- Reset release with memory always ready, `im_rdata`=addr: handovers at PC 0,4,8 every 2 cycles; `IM_Instruction` matches the address; `stall` pattern 1,0,1,0.
- `branch_taken` with target 32'h100 during DATA, with `im_rvalid` held off for 3 cycles: the response for the old address is dropped; the next `im_addr`=32'h100; `stall` stays 1 until the 32'h100 data arrives.
- Same-cycle `trap_en` (vector 32'h200) and `branch_taken` (32'h80) at handover: next `im_addr`=32'h200.
- `WFI`=1 after a handover: `im_req` stays 0 for 10 cycles. Then `interrupt_pulse` with `trap_en` (vector 32'h40): the next fetch is 32'h40.
- `pc_write`=0 at handover of PC 8: the next `im_addr`=8; `PC_out` stays 8.
- With `IF_FETCH_TIMEOUT_EN`: `im_rvalid` is held 0 for 255 cycles in DATA; `fetch_err` rises and stays 1 after a later valid response.
